// File: rtl/op_trans_pkg.sv
// rtl/op_trans_pkg.sv - shared state enum and sizing helper for the streaming transpose
package op_trans_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } trans_state_e;

    // Counter width that stays at least one bit for degenerate 1-deep dimensions
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/transpose_stream_bank.sv
// rtl/transpose_stream_bank.sv - ROWS x COLS element store with row write port and column read mux
module transpose_stream_bank
    import op_trans_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int WR_W       = clog2_min1(ROWS),
    parameter int RD_W       = clog2_min1(COLS)
) (
    input  logic                       clk_p,
    input  logic                       wr_en,
    input  logic [WR_W-1:0]            wr_row,
    input  logic [COLS*DATA_WIDTH-1:0] wr_data,
    input  logic [RD_W-1:0]            rd_col,
    output logic [ROWS*DATA_WIDTH-1:0] rd_data
);

    // Storage is deliberately left unreset; a reset only discards the tile in flight
    logic [COLS*DATA_WIDTH-1:0] mem [ROWS];

    always_ff @(posedge clk_p) begin
        if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            rd_data[r*DATA_WIDTH +: DATA_WIDTH] = mem[r][rd_col*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/transpose_stream.sv
// rtl/transpose_stream.sv - row-in/column-out tile transpose; TRANSPOSE_STREAM_PINGPONG_EN selects two banks
module transpose_stream
    import op_trans_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4
) (
    input  logic                       clk_p,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [COLS*DATA_WIDTH-1:0] in_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ROWS*DATA_WIDTH-1:0] out_col,
    output logic                       out_last
);

    localparam int WR_W = clog2_min1(ROWS);
    localparam int RD_W = clog2_min1(COLS);

    logic [WR_W-1:0] wr_cnt;
    logic [RD_W-1:0] rd_cnt;
    logic            in_fire;
    logic            out_fire;
    logic            wr_last;
    logic            rd_last;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign wr_last  = (wr_cnt == WR_W'(ROWS - 1));
    assign rd_last  = (rd_cnt == RD_W'(COLS - 1));
    assign out_last = out_valid && rd_last;

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (in_fire) begin
                wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
            end
            if (out_fire) begin
                rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
            end
        end
    end

`ifdef TRANSPOSE_STREAM_PINGPONG_EN

    logic                       wr_bank;
    logic                       rd_bank;
    logic [1:0]                 full;
    logic [1:0]                 full_nxt;
    logic [ROWS*DATA_WIDTH-1:0] bank_col [2];

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign out_col   = bank_col[rd_bank];

    // A bank cannot be written and drained at once, so the set and clear never collide
    always_comb begin
        full_nxt = full;
        if (out_fire && rd_last) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (in_fire && wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            full <= full_nxt;
            if (in_fire && wr_last) begin
                wr_bank <= ~wr_bank;
            end
            if (out_fire && rd_last) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        transpose_stream_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ROWS       (ROWS),
            .COLS       (COLS)
        ) u_bank (
            .clk_p   (clk_p),
            .wr_en   (in_fire && (wr_bank == 1'(b))),
            .wr_row  (wr_cnt),
            .wr_data (in_row),
            .rd_col  (rd_cnt),
            .rd_data (bank_col[b])
        );
    end

`else

    trans_state_e state;
    trans_state_e state_nxt;

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && wr_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && rd_last) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    transpose_stream_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROWS       (ROWS),
        .COLS       (COLS)
    ) u_bank (
        .clk_p   (clk_p),
        .wr_en   (in_fire),
        .wr_row  (wr_cnt),
        .wr_data (in_row),
        .rd_col  (rd_cnt),
        .rd_data (out_col)
    );

`endif

endmodule

// File: tb/tb_transpose_stream.sv
// tb/tb_transpose_stream.sv - directed bench for transpose_stream (4x4 and 2x3 instances)
module tb_transpose_stream;

    logic        clk_p = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [31:0] in_row, out_col;
    logic        in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
    logic [23:0] in_row2;
    logic [15:0] out_col2;
    int          passed = 0;
    int          total  = 0;

    always #5 clk_p = ~clk_p;

    transpose_stream #(.DATA_WIDTH(8), .ROWS(4), .COLS(4)) u_dut (
        .clk_p(clk_p), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col), .out_last(out_last)
    );

    transpose_stream #(.DATA_WIDTH(8), .ROWS(2), .COLS(3)) u_dut23 (
        .clk_p(clk_p), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_row(in_row2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_col(out_col2), .out_last(out_last2)
    );

    task automatic tick;
        @(posedge clk_p);
        #1;
    endtask

    function automatic logic [31:0] tile_row(input logic [7:0] base, input int r);
        logic [31:0] v;
        for (int c = 0; c < 4; c++) v[c*8 +: 8] = base + 8'(r*16 + c);
        return v;
    endfunction

    function automatic logic [31:0] tile_col(input logic [7:0] base, input int c);
        logic [31:0] v;
        for (int r = 0; r < 4; r++) v[r*8 +: 8] = base + 8'(r*16 + c);
        return v;
    endfunction

    task automatic test_reset;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", out_last); else passed++;
        total++; if (out_valid2 !== 1'b0) $display("FAIL reset_out_valid_2x3: got %b want 0", out_valid2); else passed++;
        rst_n = 1'b1;
        tick;
        total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_basic;
        for (int r = 0; r < 4; r++) begin
            in_valid = 1'b1;
            in_row   = tile_row(8'h00, r);
            total++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready row%0d: got %b want 1", r, in_ready); else passed++;
            if (r == 3) begin
                total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", out_valid); else passed++;
            end
            tick;
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) $display("FAIL basic_latency: out_valid got %b want 1", out_valid); else passed++;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            total++; if (out_col !== tile_col(8'h00, c)) $display("FAIL basic_col%0d: got %h want %h", c, out_col, tile_col(8'h00, c)); else passed++;
            total++; if (out_last !== ((c == 3) ? 1'b1 : 1'b0)) $display("FAIL basic_last%0d: got %b", c, out_last); else passed++;
            tick;
        end
        total++; if (out_valid !== 1'b0) $display("FAIL basic_drained: out_valid got %b want 0", out_valid); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_nonsquare;
        logic [15:0] exp_col [3];
        exp_col[0] = 16'h1000;
        exp_col[1] = 16'h1101;
        exp_col[2] = 16'h1202;
        in_valid2 = 1'b1;
        in_row2   = 24'h020100;
        tick;
        in_row2   = 24'h121110;
        total++; if (out_valid2 !== 1'b0) $display("FAIL ns_early_valid: got %b want 0", out_valid2); else passed++;
        tick;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            total++; if (out_valid2 !== 1'b1) $display("FAIL ns_valid%0d: got %b want 1", c, out_valid2); else passed++;
            total++; if (out_col2 !== exp_col[c]) $display("FAIL ns_col%0d: got %h want %h", c, out_col2, exp_col[c]); else passed++;
            total++; if (out_last2 !== ((c == 2) ? 1'b1 : 1'b0)) $display("FAIL ns_last%0d: got %b", c, out_last2); else passed++;
            tick;
        end
        total++; if (out_valid2 !== 1'b0) $display("FAIL ns_drained: got %b want 0", out_valid2); else passed++;
        out_ready2 = 1'b0;
    endtask

    task automatic test_signed;
        for (int r = 0; r < 4; r++) begin
            in_valid = 1'b1;
            in_row   = (r % 2 == 0) ? 32'hFF80FF80 : 32'h80FF80FF;
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (out_col !== ((c % 2 == 0) ? 32'hFF80FF80 : 32'h80FF80FF))
                $display("FAIL signed_col%0d: got %h", c, out_col);
            else passed++;
            tick;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        for (int r = 0; r < 4; r++) begin
            in_valid = 1'b1;
            in_row   = tile_row(8'h05, r);
            tick;
        end
`ifdef TRANSPOSE_STREAM_PINGPONG_EN
        in_valid = 1'b0;
`else
        in_valid = 1'b1;
        in_row   = 32'hDEADBEEF;
`endif
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++; if (out_valid !== 1'b1) $display("FAIL bp_valid%0d: got %b want 1", i, out_valid); else passed++;
            total++; if (out_col !== tile_col(8'h05, 0)) $display("FAIL bp_col%0d: got %h want %h", i, out_col, tile_col(8'h05, 0)); else passed++;
`ifndef TRANSPOSE_STREAM_PINGPONG_EN
            total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); else passed++;
`endif
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            total++; if (out_col !== tile_col(8'h05, c)) $display("FAIL bp_release_col%0d: got %h want %h", c, out_col, tile_col(8'h05, c)); else passed++;
            tick;
        end
        total++; if (out_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", out_valid); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_tile;
        for (int r = 0; r < 2; r++) begin
            in_valid = 1'b1;
            in_row   = 32'hEEEEEEEE;
            tick;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid%0d: got %b want 0", i, out_valid); else passed++;
            total++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready%0d: got %b want 1", i, in_ready); else passed++;
            tick;
        end
        rst_n = 1'b1;
        tick;
        for (int r = 0; r < 4; r++) begin
            in_valid = 1'b1;
            in_row   = tile_row(8'h0A, r);
            total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_early_valid%0d: got %b want 0", r, out_valid); else passed++;
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            total++; if (out_col !== tile_col(8'h0A, c)) $display("FAIL mid_rst_col%0d: got %h want %h", c, out_col, tile_col(8'h0A, c)); else passed++;
            tick;
        end
        out_ready = 1'b0;
    endtask

`ifdef TRANSPOSE_STREAM_PINGPONG_EN
    task automatic test_pingpong;
        int  ti = 0, ri = 0, ot = 0, oc = 0;
        logic in_f, out_f;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && ot < 3; cyc++) begin
            if (ti < 3) begin
                in_valid = 1'b1;
                in_row   = tile_row(8'(ti*3 + 1), ri);
            end else begin
                in_valid = 1'b0;
            end
            if (cyc < 12) begin
                total++; if (in_ready !== 1'b1) $display("FAIL pp_in_ready cyc%0d: got %b want 1", cyc, in_ready); else passed++;
            end
            if (cyc >= 4 && cyc < 16) begin
                total++; if (out_valid !== 1'b1) $display("FAIL pp_out_valid cyc%0d: got %b want 1", cyc, out_valid); else passed++;
            end
            in_f  = in_valid && in_ready;
            out_f = out_valid && out_ready;
            if (out_f) begin
                total++; if (out_col !== tile_col(8'(ot*3 + 1), oc)) $display("FAIL pp_col t%0d c%0d: got %h want %h", ot, oc, out_col, tile_col(8'(ot*3 + 1), oc)); else passed++;
                total++; if (out_last !== ((oc == 3) ? 1'b1 : 1'b0)) $display("FAIL pp_last t%0d c%0d: got %b", ot, oc, out_last); else passed++;
            end
            tick;
            if (in_f) begin
                ri++;
                if (ri == 4) begin ri = 0; ti++; end
            end
            if (out_f) begin
                oc++;
                if (oc == 4) begin oc = 0; ot++; end
            end
        end
        in_valid = 1'b0;
        total++; if (ot !== 3) $display("FAIL pp_tiles_out: got %0d want 3", ot); else passed++;
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_row     = '0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        in_row2    = '0;
        out_ready2 = 1'b0;
        tick;
        tick;
        test_reset;
        test_basic;
        test_nonsquare;
        test_signed;
        test_backpressure;
        test_reset_mid_tile;
`ifdef TRANSPOSE_STREAM_PINGPONG_EN
        test_pingpong;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
